dmem_responder: RTL and testbench

Data memory responder for the 16-bit RISC core: the target side of the core's load/store port. It accepts one word request at a time through a valid/ready handshake and inserts a programmable number of wait states. It then performs the read or write on an internal word array and returns the read data and an error flag through a second valid/ready handshake. It lets the core be verified, and later pipelined, against a memory with non-zero, stallable latency instead of a combinational array.

---
 rtl/dmem_responder.sv | 93 +++++++++
 tb/tb_dmem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-array load/store target: accepts one request, waits WAIT_CYCLES, accesses the array, holds the response.
// Response valid WAIT_CYCLES+2 cycles after acceptance; stalls in RESP with outputs frozen while rsp_ready is low.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] txn_count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          wr_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   mem [DEPTH];
    logic          err;
    logic [AW-1:0] idx;

    assign err       = addr_q[0] | ({1'b0, addr_q[15:1]} >= DEPTH_W);
    assign idx       = addr_q[AW:1];
    // Held low during reset even though the state is already IDLE.
    assign req_ready = (state == S_IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            rsp_err   <= 1'b0;
            txn_count <= 16'h0000;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    rsp_err   <= err;
                    rsp_rdata <= (!err && !wr_q) ? mem[idx] : 16'h0000;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Store commits on the ACCESS exit edge; a reset on that edge aborts it.
    always_ff @(posedge clk) begin
        if (!rst && state == S_ACCESS && wr_q && !err) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses WAIT_CYCLES=1, instances 1..3 use 0, 3 and 15.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv  [4];
    logic        rr  [4];
    logic        rw  [4];
    logic [15:0] ra  [4];
    logic [15:0] rwd [4];
    logic        sv  [4];
    logic        sr  [4];
    logic [15:0] sd  [4];
    logic        se  [4];
    logic [15:0] tc  [4];

    int          total = 0;
    int          bad   = 0;
    int unsigned exp_cnt = 0;
    logic [15:0] ref_mem [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dmem_responder #(
            .DEPTH      (256),
            .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(rv[g]),
            .req_ready(rr[g]),
            .req_write(rw[g]),
            .req_addr (ra[g]),
            .req_wdata(rwd[g]),
            .rsp_valid(sv[g]),
            .rsp_ready(sr[g]),
            .rsp_rdata(sd[g]),
            .rsp_err  (se[g]),
            .txn_count(tc[g])
        );
    end

    // Presents a request, waits for acceptance, returns cycles until rsp_valid is seen (sampled at negedge).
    task automatic send_req(input int i, input logic wr, input logic [15:0] a, input logic [15:0] d, output int lat);
        int n;
        @(negedge clk);
        rv[i] = 1'b1; rw[i] = wr; ra[i] = a; rwd[i] = d;
        n = 0;
        while (rr[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout inst=%0d req_ready=%b required 1", i, rr[i]);
        end
        @(posedge clk);
        #1;
        rv[i] = 1'b0;
        lat = 0;
        while (sv[i] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) begin
            total++; bad++;
            $display("FAIL rsp_timeout inst=%0d rsp_valid=%b required 1", i, sv[i]);
        end
    endtask

    task automatic do_txn(input int i, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rdata, output logic err, output int lat);
        sr[i] = 1'b1;
        send_req(i, wr, a, d, lat);
        rdata = sd[i];
        err   = se[i];
        @(negedge clk);
        if (i == 0) exp_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 16'h0; rwd[i] = 16'h0; sr[i] = 1'b1;
        end
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 16'h0010; rwd[0] = 16'hDEAD;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (rr[0] !== 1'b0) begin bad++; $display("FAIL reset_ready_low cyc=%0d got=%b required 0", k, rr[0]); end
            total++;
            if (sv[0] !== 1'b0) begin bad++; $display("FAIL reset_no_rsp cyc=%0d got=%b required 0", k, sv[0]); end
        end
        rst = 1'b0;
        rv[0] = 1'b0;
        #1;
        total++;
        if (rr[0] !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b required 1", rr[0]); end
        total++;
        if (tc[0] !== 16'h0) begin bad++; $display("FAIL post_reset_count got=%h required 0000", tc[0]); end
        total++;
        if (sd[0] !== 16'h0 || se[0] !== 1'b0) begin bad++; $display("FAIL post_reset_rsp rdata=%h err=%b required 0000/0", sd[0], se[0]); end
        exp_cnt = 0;
    endtask

    task automatic test_store_load();
        logic [15:0] d; logic e; int lat;
        do_txn(0, 1'b1, 16'h0010, 16'hBEEF, d, e, lat);
        ref_mem[8] = 16'hBEEF;
        total++;
        if (lat != 3) begin bad++; $display("FAIL store_latency got=%0d required 3", lat); end
        total++;
        if (d !== 16'h0 || e !== 1'b0) begin bad++; $display("FAIL store_rsp rdata=%h err=%b required 0000/0", d, e); end
        do_txn(0, 1'b0, 16'h0010, 16'h0, d, e, lat);
        total++;
        if (d !== 16'hBEEF || e !== 1'b0) begin bad++; $display("FAIL load_back rdata=%h err=%b required beef/0", d, e); end
        total++;
        if (tc[0] !== 16'd2) begin bad++; $display("FAIL count_two got=%0d required 2", tc[0]); end
    endtask

    task automatic test_latency();
        logic [15:0] d; logic e; int lat;
        int exp_lat [4] = '{3, 2, 5, 17};
        for (int i = 1; i < 4; i++) begin
            do_txn(i, 1'b1, 16'h0000, 16'hA5A0 + 16'(i), d, e, lat);
            total++;
            if (lat != exp_lat[i]) begin bad++; $display("FAIL store_lat inst=%0d got=%0d required %0d", i, lat, exp_lat[i]); end
            do_txn(i, 1'b0, 16'h0000, 16'h0, d, e, lat);
            total++;
            if (lat != exp_lat[i]) begin bad++; $display("FAIL load_lat inst=%0d got=%0d required %0d", i, lat, exp_lat[i]); end
            total++;
            if (d !== 16'hA5A0 + 16'(i)) begin bad++; $display("FAIL lat_data inst=%0d got=%h required %h", i, d, 16'hA5A0 + 16'(i)); end
        end
    endtask

    task automatic test_errors();
        logic [15:0] d; logic e; int lat;
        do_txn(0, 1'b1, 16'h0200, 16'h7777, d, e, lat);
        total++;
        if (e !== 1'b1 || d !== 16'h0) begin bad++; $display("FAIL err_range_store err=%b rdata=%h required 1/0000", e, d); end
        total++;
        if (tc[0] !== 16'(exp_cnt)) begin bad++; $display("FAIL err_count_a got=%0d required %0d", tc[0], exp_cnt); end
        do_txn(0, 1'b0, 16'h0011, 16'h0, d, e, lat);
        total++;
        if (e !== 1'b1 || d !== 16'h0) begin bad++; $display("FAIL err_misalign_load err=%b rdata=%h required 1/0000", e, d); end
        total++;
        if (tc[0] !== 16'(exp_cnt)) begin bad++; $display("FAIL err_count_b got=%0d required %0d", tc[0], exp_cnt); end
        do_txn(0, 1'b1, 16'h0011, 16'h6666, d, e, lat);
        do_txn(0, 1'b0, 16'h0010, 16'h0, d, e, lat);
        total++;
        if (d !== 16'hBEEF || e !== 1'b0) begin bad++; $display("FAIL err_no_corrupt rdata=%h err=%b required beef/0", d, e); end
        total++;
        if (tc[0] !== 16'(exp_cnt)) begin bad++; $display("FAIL err_count_c got=%0d required %0d", tc[0], exp_cnt); end
    endtask

    task automatic test_backpressure();
        int lat;
        sr[0] = 1'b0;
        send_req(0, 1'b0, 16'h0010, 16'h0, lat);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (sv[0] !== 1'b1 || sd[0] !== 16'hBEEF || se[0] !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc=%0d valid=%b rdata=%h err=%b required 1/beef/0", k, sv[0], sd[0], se[0]);
            end
            total++;
            if (rr[0] !== 1'b0) begin bad++; $display("FAIL bp_ready_low cyc=%0d got=%b required 0", k, rr[0]); end
        end
        total++;
        if (tc[0] !== 16'(exp_cnt)) begin bad++; $display("FAIL bp_no_count got=%0d required %0d", tc[0], exp_cnt); end
        sr[0] = 1'b1;
        @(negedge clk);
        exp_cnt++;
        total++;
        if (sv[0] !== 1'b0 || rr[0] !== 1'b1) begin bad++; $display("FAIL bp_release valid=%b ready=%b required 0/1", sv[0], rr[0]); end
        total++;
        if (tc[0] !== 16'(exp_cnt)) begin bad++; $display("FAIL bp_count got=%0d required %0d", tc[0], exp_cnt); end
        @(negedge clk);
        total++;
        if (tc[0] !== 16'(exp_cnt) || sv[0] !== 1'b0) begin bad++; $display("FAIL bp_no_dup count=%0d valid=%b required %0d/0", tc[0], sv[0], exp_cnt); end
    endtask

    task automatic test_random();
        logic [14:0] pool [6];
        logic [15:0] a, d, rd, exp_d;
        logic        wr, e, exp_e;
        int          lat, kind, stall;
        for (int p = 0; p < 6; p++) begin
            pool[p] = 15'($urandom_range(0, 255));
            d = 16'($urandom);
            do_txn(0, 1'b1, {pool[p], 1'b0}, d, rd, e, lat);
            ref_mem[pool[p][7:0]] = d;
            total++;
            if (e !== 1'b0) begin bad++; $display("FAIL prefill_err p=%0d got=%b required 0", p, e); end
        end
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 9);
            wr   = 1'($urandom_range(0, 1));
            d    = 16'($urandom);
            if (kind == 0)      a = 16'($urandom) | 16'h0001;
            else if (kind == 1) a = 16'($urandom_range(256, 32767)) << 1;
            else                a = {pool[$urandom_range(0, 5)], 1'b0};
            exp_e = a[0] || (a[15:1] >= 15'd256);
            exp_d = (exp_e || wr) ? 16'h0 : ref_mem[a[8:1]];
            stall = $urandom_range(0, 3);
            sr[0] = (stall == 0);
            send_req(0, wr, a, d, lat);
            for (int j = 0; j < stall; j++) @(negedge clk);
            rd = sd[0];
            e  = se[0];
            sr[0] = 1'b1;
            @(negedge clk);
            if (!exp_e && wr) ref_mem[a[8:1]] = d;
            exp_cnt++;
            total++;
            if (lat != 3) begin bad++; $display("FAIL rnd_lat k=%0d got=%0d required 3", k, lat); end
            total++;
            if (rd !== exp_d || e !== exp_e) begin
                bad++; $display("FAIL rnd_rsp k=%0d addr=%h wr=%b rdata=%h err=%b required %h/%b", k, a, wr, rd, e, exp_d, exp_e);
            end
            total++;
            if (tc[0] !== 16'(exp_cnt)) begin bad++; $display("FAIL rnd_count k=%0d got=%0d required %0d", k, tc[0], exp_cnt); end
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] d; logic e; int lat;
        do_txn(0, 1'b1, 16'h0020, 16'h5555, d, e, lat);
        ref_mem[16] = 16'h5555;
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 16'h0020; rwd[0] = 16'h1234;
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        total++;
        if (sv[0] !== 1'b0 || tc[0] !== 16'h0) begin bad++; $display("FAIL midop_reset valid=%b count=%0d required 0/0", sv[0], tc[0]); end
        do_txn(0, 1'b0, 16'h0020, 16'h0, d, e, lat);
        total++;
        if (d !== 16'h5555 || e !== 1'b0) begin bad++; $display("FAIL midop_no_write rdata=%h err=%b required 5555/0", d, e); end
        total++;
        if (tc[0] !== 16'd1) begin bad++; $display("FAIL midop_count got=%0d required 1", tc[0]); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_latency();
        test_errors();
        test_backpressure();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, required completion before time 500000");
        $fatal(1, "watchdog");
    end

endmodule
